// File: rtl/program_loader_pkg.sv
// Shared loader definitions: FSM state encodings and the default
// terminator instruction.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOW   = 3'd1,
    HIGH  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [15:0] HALT_WORD_DEF = 16'h0000;

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Little-endian byte pair capture; pair flags a complete word
// the cycle after the high byte lands.
module program_loader_byte_assembler #(
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cap_low,
  input  logic               cap_high,
  input  logic [NB_BYTE-1:0] rx_byte,
  output logic [NB_BYTE-1:0] low,
  output logic [NB_BYTE-1:0] high,
  output logic               pair
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low  <= '0;
      high <= '0;
      pair <= 1'b0;
    end else begin
      if (cap_low)
        low <= rx_byte;
      if (cap_high)
        high <= rx_byte;
      pair <= cap_high;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads instruction RAM from a byte stream, holding the CPU in
// reset until the halt word is written or the RAM fills.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_BYTE        = 8,
  parameter int NB_ADDR        = 10,
  parameter int RAM_DEPTH      = 2**NB_ADDR,
  parameter logic [NB_INSTRUCTION-1:0] HALT_WORD =
    NB_INSTRUCTION'(HALT_WORD_DEF)
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [NB_BYTE-1:0]        i_rx_data,
  input  logic                      i_rx_valid,
  output logic                      o_write_enable,
  output logic [NB_ADDR-1:0]        o_write_address,
  output logic [NB_INSTRUCTION-1:0] o_data,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_overflow,
  output logic                      o_cpu_reset
);

  localparam logic [NB_ADDR-1:0] LAST_ADDR =
    NB_ADDR'(RAM_DEPTH - 1);

  state_t state, next;
  logic [NB_ADDR-1:0] count;
  logic [NB_BYTE-1:0] low, high;
  logic [NB_INSTRUCTION-1:0] word;
  logic pair, ovf;
  logic cap_low, cap_high;
  logic clr, inc, set_ovf;

  program_loader_byte_assembler #(
    .NB_BYTE(NB_BYTE)
  ) u_asm (
    .clk     (i_clock),
    .rst_n   (i_reset),
    .cap_low (cap_low),
    .cap_high(cap_high),
    .rx_byte (i_rx_data),
    .low     (low),
    .high    (high),
    .pair    (pair)
  );

  assign word = {high, low};

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= next;
      if (clr)
        count <= '0;
      else if (inc)
        count <= count + 1'b1;
      if (clr)
        ovf <= 1'b0;
      else if (set_ovf)
        ovf <= 1'b1;
    end
  end

  always_comb begin
    next     = state;
    cap_low  = 1'b0;
    cap_high = 1'b0;
    clr      = 1'b0;
    inc      = 1'b0;
    set_ovf  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (i_start) begin
          clr  = 1'b1;
          next = LOW;
        end
      end
      LOW: begin
        if (i_rx_valid) begin
          cap_low = 1'b1;
          next    = HIGH;
        end
      end
      HIGH: begin
        if (i_rx_valid) begin
          cap_high = 1'b1;
          next     = WRITE;
        end
      end
      WRITE: begin
        if (word == HALT_WORD) begin
          next = DONE;
        end else if (count == LAST_ADDR) begin
          set_ovf = 1'b1;
          next    = DONE;
        end else begin
          // a byte arriving during the write starts the next word
          inc = 1'b1;
          if (i_rx_valid) begin
            cap_low = 1'b1;
            next    = HIGH;
          end else begin
            next = LOW;
          end
        end
      end
      default: next = IDLE;
    endcase
  end

  assign o_write_enable  = pair;
  assign o_write_address = count;
  assign o_data          = word;
  assign o_busy     = (state == LOW) || (state == HIGH)
                   || (state == WRITE);
  assign o_done     = (state == DONE);
  assign o_overflow = ovf;
  assign o_cpu_reset = (state != DONE);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a 4-word RAM so the
// overflow stop is reachable.
module tb_program_loader;

  localparam int NA = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        we;
  logic [NA-1:0] addr;
  logic [15:0] data;
  logic        busy, done, ovf, cpu_rst;

  int checks = 0;
  int failures = 0;

  logic [NA-1:0] log_addr[$];
  logic [15:0]   log_data[$];

  program_loader #(
    .NB_ADDR(NA)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_start        (start),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .o_write_enable (we),
    .o_write_address(addr),
    .o_data         (data),
    .o_busy         (busy),
    .o_done         (done),
    .o_overflow     (ovf),
    .o_cpu_reset    (cpu_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) begin
      log_addr.push_back(addr);
      log_data.push_back(data);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] b[]);
    foreach (b[i]) begin
      @(negedge clk);
      rx_data  = b[i];
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_log(input string tag, input int n,
                           input logic [15:0] w[]);
    check({tag, "_count"}, log_data.size(), n);
    for (int i = 0; i < n && i < log_data.size(); i++) begin
      check({tag, "_addr"}, 32'(log_addr[i]), i);
      check({tag, "_data"}, 32'(log_data[i]), 32'(w[i]));
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_we"},   we, 0);
    check({tag, "_addr"}, 32'(addr), 0);
    check({tag, "_data"}, 32'(data), 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ovf"},  ovf, 0);
    check({tag, "_cpur"}, cpu_rst, 1);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    #1;
    check_reset_outs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // bytes before start are ignored
    send_stream('{8'h34, 8'h12, 8'h00, 8'h00});
    check("pre_busy", busy, 0);
    check("pre_writes", log_data.size(), 0);

    // basic load with latency checks
    clear_log();
    pulse_start();
    check("start_busy", busy, 1);
    check("start_cpur", cpu_rst, 1);
    send_byte(8'h34);
    send_byte(8'h12);
    check("lat_we", we, 1);
    check("lat_addr", 32'(addr), 0);
    check("lat_data", 32'(data), 32'h1234);
    @(negedge clk);
    check("lat_we_off", we, 0);
    check("lat_addr_inc", 32'(addr), 1);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h00);
    @(negedge clk);
    rx_data  = 8'h00;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check("halt_we", we, 1);
    check("halt_addr", 32'(addr), 2);
    check("halt_cpur", cpu_rst, 1);
    @(negedge clk);
    check("end_we", we, 0);
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_ovf", ovf, 0);
    check("end_cpur", cpu_rst, 0);
    check_log("basic", 3, '{16'h1234, 16'h5678, 16'h0000});

    // back-to-back bytes, including during the write cycle
    clear_log();
    pulse_start();
    check("b2b_done_clr", done, 0);
    send_stream('{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00});
    @(negedge clk);
    check("b2b_done", done, 1);
    check_log("b2b", 3, '{16'h2211, 16'h4433, 16'h0000});

    // overflow: four non-halt words fill the RAM
    clear_log();
    pulse_start();
    send_stream('{8'h01, 8'h00, 8'h02, 8'h00,
                  8'h03, 8'h00, 8'h04, 8'h00});
    @(negedge clk);
    check("ovf_flag", ovf, 1);
    check("ovf_done", done, 1);
    check("ovf_cpur", cpu_rst, 0);
    send_stream('{8'h05, 8'h00});
    repeat (2) @(negedge clk);
    check_log("ovf", 4,
              '{16'h0001, 16'h0002, 16'h0003, 16'h0004});

    // restart from DONE clears flags; start while busy ignored
    clear_log();
    pulse_start();
    check("rs_ovf_clr", ovf, 0);
    check("rs_done_clr", done, 0);
    check("rs_addr", 32'(addr), 0);
    send_byte(8'h78);
    pulse_start();
    check("rs_busy", busy, 1);
    send_byte(8'h56);
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    check("rs_done", done, 1);
    check_log("rs", 2, '{16'h5678, 16'h0000});

    // asynchronous reset mid-load
    clear_log();
    pulse_start();
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h78);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outs("mid");
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    pulse_start();
    send_byte(8'hAB);
    send_byte(8'hCD);
    check("mid_re_data", 32'(data), 32'hCDAB);
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    check("mid_re_done", done, 1);
    check_log("mid_re", 2, '{16'hCDAB, 16'h0000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
